seven_segment_display_engine: RTL and testbench

Parametrised successor to the basic hex scan controller for the 7-seg board display. It multiplexes NUM_DIGITS digits, selectable hex or decimal display, leading-zero blanking, per-digit decimal points and PWM brightness. Decimal mode converts binary to BCD internally using a sequential double-dabble engine (one bit per cycle) with overflow detection. It sits between top-level debug/status values and the board cathode/anode pins.

---
 rtl/seven_segment_display_engine.sv | 169 ++++++++++++++++
 tb/tb_seven_segment_display_engine.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_display_engine.sv
// Multiplexed N-digit 7-segment driver with hex/decimal display, leading-zero
// blanking, per-digit decimal points, PWM brightness and a serial double-dabble converter.
module seven_segment_display_engine #(
  parameter int NUM_DIGITS = 8,
  parameter int COUNT_TO   = 100_000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic                  load_in,
  input  logic                  dec_mode_in,
  input  logic                  blank_lz_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [3:0]            bright_in,
  output logic [6:0]            cat_out,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic                  busy_out,
  output logic                  ovf_out
);
  localparam int W      = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W = (COUNT_TO > 0) ? $clog2(COUNT_TO + 1) : 1;
  localparam int BIT_W  = $clog2(W + 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      disp_q, disp_d;
  logic [W-1:0]      bin_q, bin_d;
  logic [W-1:0]      bcd_q, bcd_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              ovf_q, ovf_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        pwm_cnt_q, pwm_cnt_d;

  logic [W-1:0]          bcd_adj;
  logic [W-1:0]          bcd_shift;
  logic [NUM_DIGITS-1:0] lz;
  logic [3:0]            nib;
  logic [6:0]            seg;
  logic                  blank;
  logic                  lit;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      disp_q     <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      ovf_acc_q  <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      disp_q     <= disp_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      bit_cnt_q  <= bit_cnt_d;
      ovf_q      <= ovf_d;
      ovf_acc_q  <= ovf_acc_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      pwm_cnt_q  <= pwm_cnt_d;
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    if (scan_cnt_q == SCAN_W'(COUNT_TO)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Double-dabble step: correct each BCD nibble, then shift one binary bit in.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[W-2:0], bin_q[W-1]};
  end

  always_comb begin
    state_d   = state_q;
    disp_d    = disp_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    ovf_d     = ovf_q;
    ovf_acc_d = ovf_acc_q;
    case (state_q)
      IDLE: begin
        if (load_in && dec_mode_in) begin
          bin_d     = val_in;
          bcd_d     = '0;
          bit_cnt_d = '0;
          ovf_acc_d = 1'b0;
          state_d   = CONVERT;
        end else if (load_in) begin
          disp_d = val_in;
          ovf_d  = 1'b0;
        end
      end
      CONVERT: begin
        bcd_d     = bcd_shift;
        bin_d     = {bin_q[W-2:0], 1'b0};
        ovf_acc_d = ovf_acc_q | bcd_adj[W-1];
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_W'(W - 1)) begin
          state_d = IDLE;
          disp_d  = bcd_shift;
          ovf_d   = ovf_acc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // lz[i] is set when nibble i and every nibble above it are zero.
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = (disp_q[W-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (disp_q[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    nib   = disp_q[4*idx_q +: 4];
    blank = blank_lz_in && (idx_q != '0) && lz[idx_q];
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    if (ovf_q)      cat_out = 7'b0111111;
    else if (blank) cat_out = 7'h7F;
    else            cat_out = ~seg;
    dp_out = ~dp_in[idx_q];
    lit    = (bright_in == 4'hF) || (pwm_cnt_q < bright_in);
    an_out = '1;
    if (lit) an_out[idx_q] = 1'b0;
    busy_out = (state_q == CONVERT);
    ovf_out  = ovf_q;
  end

endmodule

// File: tb/tb_seven_segment_display_engine.sv
// Self-checking bench for seven_segment_display_engine (4 digits, 4-cycle dwell)
// against an arithmetic model of the displayed value.
module tb_seven_segment_display_engine;
  localparam int N  = 4;
  localparam int CT = 3;
  localparam int W  = 4 * N;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic [W-1:0]   val_in;
  logic           load_in;
  logic           dec_mode_in;
  logic           blank_lz_in;
  logic [N-1:0]   dp_in;
  logic [3:0]     bright_in;
  logic [6:0]     cat_out;
  logic           dp_out;
  logic [N-1:0]   an_out;
  logic           busy_out;
  logic           ovf_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int m_val;
  bit m_hex;
  bit m_ovf;
  logic [6:0] seg_tbl [16];

  seven_segment_display_engine #(.NUM_DIGITS(N), .COUNT_TO(CT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .val_in(val_in), .load_in(load_in),
    .dec_mode_in(dec_mode_in), .blank_lz_in(blank_lz_in), .dp_in(dp_in),
    .bright_in(bright_in), .cat_out(cat_out), .dp_out(dp_out), .an_out(an_out),
    .busy_out(busy_out), .ovf_out(ovf_out)
  );

  always #5 clk_in = ~clk_in;

  // Cycles elapsed since the last reset edge; scan slot and PWM phase derive from it.
  always @(posedge clk_in) begin
    if (rst_in) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_out && n < 100) begin
      step();
      n++;
    end
  endtask

  function automatic int exp_idx();
    return (cyc / (CT + 1)) % N;
  endfunction

  function automatic logic [6:0] exp_cat(int d);
    int base, pw, dig;
    base = m_hex ? 16 : 10;
    pw   = 1;
    for (int k = 0; k < d; k++) pw = pw * base;
    dig = (m_val / pw) % base;
    if (m_ovf) return 7'b0111111;
    if (blank_lz_in && d > 0 && m_val < pw) return 7'h7F;
    return ~seg_tbl[dig];
  endfunction

  function automatic logic [N-1:0] exp_an();
    logic [N-1:0] a;
    a = '1;
    if (bright_in == 4'hF || (cyc % 16) < int'(bright_in)) a[exp_idx()] = 1'b0;
    return a;
  endfunction

  task automatic test_reset();
    rst_in = 1'b1; load_in = 1'b0; dec_mode_in = 1'b0; blank_lz_in = 1'b0;
    val_in = '0; dp_in = '0; bright_in = 4'hF;
    step();
    step();
    rst_in = 1'b0;
    #1;
    m_val = 0; m_hex = 1'b1; m_ovf = 1'b0;
    tests++;
    if (an_out !== 4'b1110) begin fails++; $display("[TB] FAIL reset_an: got %b expected 1110", an_out); end
    tests++;
    if (cat_out !== 7'h40) begin fails++; $display("[TB] FAIL reset_cat: got %h expected 40", cat_out); end
    tests++;
    if (busy_out !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_out); end
    tests++;
    if (ovf_out !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf_out); end
  endtask

  task automatic test_hex_scan();
    val_in = 16'h0042; dec_mode_in = 1'b0; blank_lz_in = 1'b1; load_in = 1'b1;
    step();
    load_in = 1'b0;
    #1;
    m_val = 'h42; m_hex = 1'b1; m_ovf = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tests++;
      if (an_out !== exp_an()) begin fails++; $display("[TB] FAIL hex_an: got %b expected %b", an_out, exp_an()); end
      tests++;
      if (cat_out !== exp_cat(exp_idx())) begin
        fails++; $display("[TB] FAIL hex_cat digit %0d: got %h expected %h", exp_idx(), cat_out, exp_cat(exp_idx()));
      end
      tests++;
      if (busy_out !== 1'b0) begin fails++; $display("[TB] FAIL hex_busy: got %b expected 0", busy_out); end
      step();
    end
  endtask

  task automatic test_decimal();
    int n;
    blank_lz_in = 1'b0; val_in = 16'd1234; dec_mode_in = 1'b1; load_in = 1'b1;
    step();
    load_in = 1'b0;
    #1;
    n = 0;
    while (busy_out && n < 100) begin
      n++;
      tests++;
      if (cat_out !== exp_cat(exp_idx())) begin
        fails++; $display("[TB] FAIL dec_hold busy cycle %0d: got %h expected %h", n, cat_out, exp_cat(exp_idx()));
      end
      load_in = (n == 5);
      val_in  = 16'd9999;
      step();
    end
    load_in = 1'b0;
    tests++;
    if (n !== 16) begin fails++; $display("[TB] FAIL dec_busy_len: got %0d expected 16", n); end
    m_val = 1234; m_hex = 1'b0; m_ovf = 1'b0;
    tests++;
    if (ovf_out !== 1'b0) begin fails++; $display("[TB] FAIL dec_ovf: got %b expected 0", ovf_out); end
    for (int c = 0; c < 16; c++) begin
      tests++;
      if (cat_out !== exp_cat(exp_idx())) begin
        fails++; $display("[TB] FAIL dec_cat digit %0d: got %h expected %h", exp_idx(), cat_out, exp_cat(exp_idx()));
      end
      step();
    end
  endtask

  task automatic test_overflow();
    int n;
    blank_lz_in = 1'b1; val_in = 16'd12345; dec_mode_in = 1'b1; load_in = 1'b1;
    step();
    load_in = 1'b0;
    wait_idle(n);
    tests++;
    if (n !== 16) begin fails++; $display("[TB] FAIL ovf_busy_len: got %0d expected 16", n); end
    m_val = 12345 % 10000; m_hex = 1'b0; m_ovf = 1'b1;
    tests++;
    if (ovf_out !== 1'b1) begin fails++; $display("[TB] FAIL ovf_flag: got %b expected 1", ovf_out); end
    for (int c = 0; c < 16; c++) begin
      tests++;
      if (cat_out !== 7'b0111111) begin fails++; $display("[TB] FAIL ovf_dash digit %0d: got %h expected 3f", exp_idx(), cat_out); end
      step();
    end
    val_in = 16'h00A5; dec_mode_in = 1'b0; load_in = 1'b1;
    step();
    load_in = 1'b0;
    #1;
    m_val = 'hA5; m_hex = 1'b1; m_ovf = 1'b0;
    tests++;
    if (ovf_out !== 1'b0) begin fails++; $display("[TB] FAIL ovf_clear: got %b expected 0", ovf_out); end
    for (int c = 0; c < 8; c++) begin
      tests++;
      if (cat_out !== exp_cat(exp_idx())) begin
        fails++; $display("[TB] FAIL ovf_hex_cat digit %0d: got %h expected %h", exp_idx(), cat_out, exp_cat(exp_idx()));
      end
      step();
    end
  endtask

  task automatic test_brightness();
    int active;
    bright_in = 4'd4;
    #1;
    active = 0;
    for (int c = 0; c < 32; c++) begin
      tests++;
      if (an_out !== exp_an()) begin fails++; $display("[TB] FAIL bright4_an: got %b expected %b", an_out, exp_an()); end
      if (c < 16 && an_out !== 4'hF) active++;
      step();
    end
    tests++;
    if (active !== 4) begin fails++; $display("[TB] FAIL bright4_duty: got %0d expected 4", active); end
    bright_in = 4'd0;
    #1;
    for (int c = 0; c < 16; c++) begin
      tests++;
      if (an_out !== 4'hF) begin fails++; $display("[TB] FAIL bright0_an: got %b expected 1111", an_out); end
      step();
    end
    bright_in = 4'hF;
  endtask

  task automatic test_reset_mid();
    int n;
    blank_lz_in = 1'b0; val_in = 16'd4321; dec_mode_in = 1'b1; load_in = 1'b1;
    step();
    load_in = 1'b0;
    n = 1;
    while (n < 7) begin step(); n++; end
    tests++;
    if (busy_out !== 1'b1) begin fails++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy_out); end
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    #1;
    m_val = 0; m_hex = 1'b1; m_ovf = 1'b0;
    tests++;
    if (busy_out !== 1'b0) begin fails++; $display("[TB] FAIL mid_busy_after: got %b expected 0", busy_out); end
    tests++;
    if (cat_out !== 7'h40) begin fails++; $display("[TB] FAIL mid_cat: got %h expected 40", cat_out); end
    tests++;
    if (an_out !== 4'b1110) begin fails++; $display("[TB] FAIL mid_an: got %b expected 1110", an_out); end
    val_in = 16'd9999; dec_mode_in = 1'b1; load_in = 1'b1;
    step();
    load_in = 1'b0;
    wait_idle(n);
    tests++;
    if (n !== 16) begin fails++; $display("[TB] FAIL mid_busy_len: got %0d expected 16", n); end
    m_val = 9999; m_hex = 1'b0; m_ovf = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tests++;
      if (cat_out !== exp_cat(exp_idx())) begin
        fails++; $display("[TB] FAIL mid_9999 digit %0d: got %h expected %h", exp_idx(), cat_out, exp_cat(exp_idx()));
      end
      step();
    end
  endtask

  task automatic test_random();
    int n, v;
    bit mode;
    for (int it = 0; it < 10; it++) begin
      mode        = 1'($urandom_range(0, 1));
      v           = mode ? int'($urandom_range(0, 20000)) : int'($urandom_range(0, 65535));
      val_in      = W'(v);
      dec_mode_in = mode;
      blank_lz_in = 1'($urandom_range(0, 1));
      dp_in       = N'($urandom);
      bright_in   = 4'($urandom_range(0, 15));
      load_in     = 1'b1;
      step();
      load_in = 1'b0;
      if (mode) begin
        wait_idle(n);
        tests++;
        if (n !== 16) begin fails++; $display("[TB] FAIL rand_busy_len: got %0d expected 16", n); end
        m_val = v % 10000; m_hex = 1'b0; m_ovf = (v >= 10000);
      end else begin
        m_val = v; m_hex = 1'b1; m_ovf = 1'b0;
      end
      #1;
      tests++;
      if (ovf_out !== m_ovf) begin fails++; $display("[TB] FAIL rand_ovf val %0d: got %b expected %b", v, ovf_out, m_ovf); end
      for (int c = 0; c < 12; c++) begin
        tests++;
        if (cat_out !== exp_cat(exp_idx())) begin
          fails++; $display("[TB] FAIL rand_cat val %0d digit %0d: got %h expected %h", v, exp_idx(), cat_out, exp_cat(exp_idx()));
        end
        tests++;
        if (an_out !== exp_an()) begin fails++; $display("[TB] FAIL rand_an: got %b expected %b", an_out, exp_an()); end
        tests++;
        if (dp_out !== ~dp_in[exp_idx()]) begin
          fails++; $display("[TB] FAIL rand_dp digit %0d: got %b expected %b", exp_idx(), dp_out, ~dp_in[exp_idx()]);
        end
        step();
      end
    end
  endtask

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    test_reset();
    test_hex_scan();
    test_decimal();
    test_overflow();
    test_brightness();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
